// File: rtl/period_meter_pkg.sv
// period_meter_pkg: shared definitions for the period meter.
//   - state_t        : FSM state encoding (IDLE/ARM/MEASURE/DONE)
//   - CNT_W_DEF      : default counter width, shared with the clock divider
//   - TIMEOUT_DEF    : default abort limit in clkin cycles
//   - SYNC_STAGES_DEF: default synchronizer depth
package period_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_MEASURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam int unsigned  CNT_W_DEF       = 26;
  localparam logic [25:0]  TIMEOUT_DEF     = 26'd50_000_000;
  localparam int unsigned  SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/period_meter_sync_edge_detect.sv
// sync_edge_detect: brings an asynchronous level into the clkin domain and
// produces a one-cycle pulse on each synchronized rising edge.
// Ports:
//   clkin   - system clock
//   rst_N   - synchronous active-low reset
//   i_async - asynchronous input level
//   o_rise  - high for one cycle per synchronized rising edge
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clkin,
  input  logic rst_N,
  input  logic i_async,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  // Synchronizer chain plus the one-cycle-delayed copy used for edge detection.
  always_ff @(posedge clkin) begin
    if (!rst_N) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_rise = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/period_meter.sv
// period_meter: one-shot measurement of the period of a slow input, in clkin
// cycles, returned over a valid/ready handshake.
// Ports:
//   clkin        - system clock
//   rst_N        - synchronous active-low reset
//   sig_in       - signal to measure (asynchronous)
//   start        - one-cycle request, honoured only in IDLE
//   busy         - high in ARM, MEASURE and DONE
//   period_out   - measured period (0 on timeout)
//   period_valid - result available, held until accepted
//   period_ready - consumer accept
//   timeout      - measurement aborted
module period_meter
  import period_meter_pkg::*;
#(
  parameter int               CNT_W       = CNT_W_DEF,
  parameter logic [CNT_W-1:0] TIMEOUT     = CNT_W'(TIMEOUT_DEF),
  parameter int               SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic             clkin,
  input  logic             rst_N,
  input  logic             sig_in,
  input  logic             start,
  output logic             busy,
  output logic [CNT_W-1:0] period_out,
  output logic             period_valid,
  input  logic             period_ready,
  output logic             timeout
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] r_wait_cnt;
  logic [CNT_W-1:0] w_wait_nxt;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] w_period_nxt;
  logic             r_timeout;
  logic             w_timeout_nxt;
  logic             w_rise;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clkin  (clkin),
    .rst_N  (rst_N),
    .i_async(sig_in),
    .o_rise (w_rise)
  );

  // State, counters and result registers.
  always_ff @(posedge clkin) begin
    if (!rst_N) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_wait_cnt <= '0;
      r_period   <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_wait_cnt <= w_wait_nxt;
      r_period   <= w_period_nxt;
      r_timeout  <= w_timeout_nxt;
    end
  end

  // Next-state and datapath updates. cnt starts at 1 on the first rise so the
  // value captured on the second rise equals the number of cycles between them.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_wait_nxt    = r_wait_cnt;
    w_period_nxt  = r_period;
    w_timeout_nxt = r_timeout;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt   = ST_ARM;
          w_wait_nxt    = '0;
          w_timeout_nxt = 1'b0;
          w_period_nxt  = '0;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ARM: begin
        if (w_rise) begin
          w_state_nxt = ST_MEASURE;
          w_cnt_nxt   = CNT_W'(1);
        end else if (r_wait_cnt == TIMEOUT) begin
          w_state_nxt   = ST_DONE;
          w_timeout_nxt = 1'b1;
          w_period_nxt  = '0;
        end else begin
          w_wait_nxt = r_wait_cnt + CNT_W'(1);
        end
      end
      ST_MEASURE: begin
        if (w_rise) begin
          w_state_nxt  = ST_DONE;
          w_period_nxt = r_cnt;
        end else if (r_cnt == TIMEOUT) begin
          // Abort before the counter could wrap.
          w_state_nxt   = ST_DONE;
          w_timeout_nxt = 1'b1;
          w_period_nxt  = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (period_ready) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign busy         = (r_state != ST_IDLE);
  assign period_valid = (r_state == ST_DONE);
  assign period_out   = r_period;
  assign timeout      = r_timeout;

endmodule

// File: tb/tb_period_meter.sv
module tb_period_meter;

  localparam int CW = 26;

  typedef struct packed {
    logic [CW-1:0] p;
    logic          t;
  } exp_t;

  logic          clkin = 1'b0;
  logic          rst_N = 1'b0;
  logic          sig_in = 1'b0;
  logic          start = 1'b0;
  logic          period_ready = 1'b0;
  logic          busy;
  logic [CW-1:0] period_out;
  logic          period_valid;
  logic          timeout;

  logic wave_en    = 1'b0;
  logic hold_level = 1'b0;
  int   wave_half  = 11;
  int   wcnt       = 0;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  period_meter #(
    .CNT_W      (CW),
    .TIMEOUT    (26'd100),
    .SYNC_STAGES(2)
  ) dut (
    .clkin       (clkin),
    .rst_N       (rst_N),
    .sig_in      (sig_in),
    .start       (start),
    .busy        (busy),
    .period_out  (period_out),
    .period_valid(period_valid),
    .period_ready(period_ready),
    .timeout     (timeout)
  );

  always #5 clkin = ~clkin;

  // Behavioural clock divider: toggles sig_in every wave_half cycles.
  always @(negedge clkin) begin
    if (wave_en) begin
      if (wcnt >= wave_half - 1) begin
        sig_in = ~sig_in;
        wcnt   = 0;
      end else begin
        wcnt = wcnt + 1;
      end
    end else begin
      sig_in = hold_level;
      wcnt   = 0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clkin);
  endtask

  // Called at a negedge; start is high across exactly one rising edge.
  task automatic pulse_start(input bit push, input logic [CW-1:0] p, input logic t);
    exp_t e;
    e.p = p;
    e.t = t;
    start = 1'b1;
    if (push) sb_q.push_back(e);
    @(negedge clkin);
    start = 1'b0;
  endtask

  task automatic wait_result(input string tag, input int max_cyc, output int n);
    exp_t e;
    n = 0;
    while (period_valid !== 1'b1 && n < max_cyc) begin
      @(negedge clkin);
      n++;
    end
    chk({tag, " valid"}, {31'd0, period_valid}, 32'd1);
    chk({tag, " sb_nonempty"}, {31'd0, (sb_q.size() != 0)}, 32'd1);
    if (period_valid === 1'b1 && sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk({tag, " period"}, {6'd0, period_out}, {6'd0, e.p});
      chk({tag, " timeout"}, {31'd0, timeout}, {31'd0, e.t});
    end
  endtask

  initial begin
    int  n;
    bit  seen_valid;

    // Reset
    rst_N = 1'b0;
    cycles(3);
    rst_N = 1'b1;
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst valid", {31'd0, period_valid}, 32'd0);
    chk("rst period", {6'd0, period_out}, 32'd0);
    chk("rst timeout", {31'd0, timeout}, 32'd0);

    // Divided clock, toggle every 11 cycles, ready held high
    period_ready = 1'b1;
    wave_half    = 11;
    wave_en      = 1'b1;
    cycles(5);
    pulse_start(1'b1, 26'd22, 1'b0);
    wait_result("div22", 200, n);
    @(negedge clkin);
    chk("div22 done_one_cycle", {31'd0, period_valid}, 32'd0);
    chk("div22 idle", {31'd0, busy}, 32'd0);

    // sig_in stuck low: abort exactly 101 cycles after entering ARM
    wave_en    = 1'b0;
    hold_level = 1'b0;
    cycles(10);
    pulse_start(1'b1, 26'd0, 1'b1);
    wait_result("arm_to", 300, n);
    chk("arm_to latency", n, 32'd101);
    cycles(3);

    // One rise then held high: abort in MEASURE
    pulse_start(1'b1, 26'd0, 1'b1);
    cycles(5);
    hold_level = 1'b1;
    wait_result("meas_to", 300, n);
    cycles(3);

    // Back-pressure with ignored starts
    period_ready = 1'b0;
    wave_en      = 1'b1;
    pulse_start(1'b1, 26'd22, 1'b0);
    wait_result("bp", 200, n);
    for (int i = 0; i < 20; i++) begin
      start = (i % 2 == 0);
      @(negedge clkin);
      chk("bp hold valid", {31'd0, period_valid}, 32'd1);
      chk("bp hold period", {6'd0, period_out}, 32'd22);
    end
    start = 1'b0;
    period_ready = 1'b1;
    @(negedge clkin);
    chk("bp release valid", {31'd0, period_valid}, 32'd0);
    chk("bp release busy", {31'd0, busy}, 32'd0);
    cycles(3);
    chk("bp no queued start", {31'd0, busy}, 32'd0);

    // Reset during MEASURE
    wave_en    = 1'b0;
    hold_level = 1'b0;
    cycles(10);
    pulse_start(1'b0, 26'd0, 1'b0);
    cycles(5);
    hold_level = 1'b1;
    cycles(10);
    chk("mrst busy before", {31'd0, busy}, 32'd1);
    rst_N = 1'b0;
    @(negedge clkin);
    rst_N = 1'b1;
    chk("mrst busy", {31'd0, busy}, 32'd0);
    chk("mrst valid", {31'd0, period_valid}, 32'd0);
    chk("mrst period", {6'd0, period_out}, 32'd0);
    chk("mrst timeout", {31'd0, timeout}, 32'd0);
    seen_valid = 1'b0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clkin);
      if (period_valid === 1'b1) seen_valid = 1'b1;
    end
    chk("mrst no valid", {31'd0, seen_valid}, 32'd0);
    wave_half = 11;
    wave_en   = 1'b1;
    pulse_start(1'b1, 26'd22, 1'b0);
    wait_result("mrst remeasure", 200, n);
    cycles(2);

    // Fastest input: toggle every cycle, back-to-back measurements
    wave_half = 1;
    cycles(5);
    for (int k = 0; k < 3; k++) begin
      pulse_start(1'b1, 26'd2, 1'b0);
      wait_result("p2", 50, n);
      @(negedge clkin);
    end

    chk("sb drained", sb_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/period_meter.md
Name: period_meter

Overview:
- Measures the period of a slow square wave in clkin cycles; it converts a frequency back into a number, the inverse of the clock divider.
- Used to self-check divided clocks (traffic-light 1 Hz tick, scan clocks) and to measure external slow inputs.
- One-shot measurement per start request; the result is returned over a valid/ready handshake.
- Input sampled asynchronously through a synchronizer; everything else is in the clkin domain.

Parameters:
- CNT_W, 26, width of the period counter and period_out.
- TIMEOUT, 26'd50_000_000, max clkin cycles spent waiting in ARM or MEASURE before abort. Must be ≤ 2^CNT_W-1.
- SYNC_STAGES, 2, flip-flop stages on sig_in. Must be ≥ 2.

Ports:
- clkin  input  1  system clock; all logic on its rising edge.
- rst_N  input  1  synchronous, active-low reset.
- sig_in  input  1  signal to measure; asynchronous to clkin.
- start  input  1  single-cycle request to begin a measurement; sampled only in IDLE.
- busy  output  1  high in ARM, MEASURE and DONE.
- period_out  output  CNT_W  measured period in clkin cycles; 0 on timeout.
- period_valid  output  1  result available; held until accepted.
- period_ready  input  1  consumer accepts the result when high together with period_valid.
- timeout  output  1  qualifies period_out; high means the measurement was aborted.

Behaviour:
- Reset: synchronous, active-low (rst_N low at a clkin rising edge).
  - All state, synchronizer flops, the edge register and the counters clear.
  - Outputs after reset: busy=0, period_out=0, period_valid=0, timeout=0, FSM=IDLE.
  - Reset asserted mid-measurement discards the result with no valid pulse.
- Input conditioning: sig_in passes through SYNC_STAGES flops, then one more register. rise = sync & ~prev.
  - Pin-to-rise latency is SYNC_STAGES+1 cycles. This latency is constant, so it cancels out of the period.
- FSM states and transitions:
  - IDLE: start=1 → ARM. Clear wait_cnt and timeout.
  - ARM: waits for the first rise.
    - rise → MEASURE, cnt<=1.
    - Else wait_cnt+1; when wait_cnt==TIMEOUT → DONE with timeout=1, period_out=0.
    - A rise coinciding with the start cycle (still IDLE) is ignored.
  - MEASURE: increments cnt each cycle with no rise.
    - rise → DONE, period_out<=cnt, so period = t2−t1 exactly.
    - When cnt==TIMEOUT without a rise → DONE with timeout=1, period_out=0.
    - cnt never wraps.
  - DONE: period_valid=1.
    - period_out and timeout stay stable while valid.
    - On period_valid & period_ready → IDLE, clearing period_valid next cycle.
    - period_out and timeout keep their last value until the next start.
- Handshake and start rules:
  - start while busy is ignored (not queued).
  - period_ready while not valid has no effect.
  - period_ready may be held high permanently; DONE then lasts exactly 1 cycle.
- Minimum measurable period: 2 cycles (synchronized input toggling every cycle).
- Glitches narrower than one clkin period may be missed; this is acceptable.

Decomposition:
- Shared package:
  - FSM state encoding: IDLE=2'd0, ARM=2'd1, MEASURE=2'd2, DONE=2'd3.
  - Default CNT_W and TIMEOUT constants, shared with the clock divider.
- One sub-module, sync_edge_detect: SYNC_STAGES synchronizer plus rising-edge pulse, with clkin/rst_N.
  - It is reused for button inputs elsewhere.

Test Plan:
- Drive sig_in from the clock divider with DivideNum=10 (toggles every 11 cycles). Pulse start, hold ready=1 → period_valid with period_out=22, timeout=0.
- sig_in held at 0, TIMEOUT overridden to 100, pulse start → valid exactly 101 cycles after entering ARM; period_out=0, timeout=1.
- One rise, then sig_in held high, TIMEOUT=100 → timeout=1, period_out=0 after cnt reaches 100.
- ready=0 for 20 cycles after valid, with extra start pulses meanwhile → valid and period_out stay constant, starts ignored. Raising ready → IDLE next cycle.
- rst_N low for 1 cycle during MEASURE → next cycle all outputs 0, no valid. A new start yields the correct period, 22.
- Square wave with period 2 (toggle every cycle) → period_out=2; repeated back-to-back measurements give identical results.
